// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : imem_loader_pkg
// Shared state encoding and stream framing constants for the boot loader.
// Rev     : 1.0
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : imem_loader_if
// Byte-stream input, instruction-memory write port and core boot status.
// Rev       : 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  core_rst, load_done, load_err, words_loaded
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output core_rst, load_done, load_err, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : imem_loader_byte_packer
// Little-endian byte-to-word assembly with a registered one-cycle word pulse.
// Rev    : 1.0
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              strobe,
    input  wire logic [7:0]        byte_in,
    output logic      [DATA_W-1:0] word,
    output logic                   word_valid,
    output logic                   last_lane
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-9:0] r_asm;
    logic [DATA_W-1:0] r_word;
    logic              r_word_valid;

    assign last_lane  = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = r_word;
    assign word_valid = r_word_valid;

    // The top lane never lands in r_asm; it completes the word directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_asm        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else if (clear) begin
            r_cnt        <= '0;
            r_asm        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= strobe & last_lane;
            if (strobe) begin
                if (last_lane) begin
                    r_word <= {byte_in, r_asm};
                    r_cnt  <= '0;
                end else begin
                    r_asm[{r_cnt, 3'b000} +: 8] <= byte_in;
                    r_cnt                       <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader
// Boot loader: writes a length-prefixed byte stream into imem, then frees the core.
// Rev    : 1.0
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    imem_loader_if.slave bus
);

    localparam int LEN_W = 8 * HDR_BYTES;
    localparam int CMP_W = LEN_W + 1;
    localparam logic [LEN_W:0] c_depth = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_addr;
    logic              r_byte_ready;
    logic              r_core_rst;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_hs;
    logic              w_strobe;
    logic              w_last_lane;
    logic              w_word_write;
    logic              w_final_word;
    logic [CMP_W-1:0]  w_words_ext;
    logic [DATA_W-1:0] w_pk_word;
    logic              w_pk_valid;

    assign w_hs         = bus.byte_valid & r_byte_ready;
    assign w_strobe     = w_hs & (r_state == DATA);
    assign w_word_write = w_strobe & w_last_lane;
    assign w_words_ext  = CMP_W'(r_words) + CMP_W'(1);
    assign w_final_word = w_word_write & (w_words_ext == CMP_W'(r_len));

    imem_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (r_state != DATA),
        .strobe     (w_strobe),
        .byte_in    (bus.byte_data),
        .word       (w_pk_word),
        .word_valid (w_pk_valid),
        .last_lane  (w_last_lane)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        unique case (r_state)
            LEN0: begin
                if (w_hs) begin
                    w_len_nxt[7:0] = bus.byte_data;
                    w_state_nxt    = LEN1;
                end
            end
            LEN1: begin
                if (w_hs) begin
                    w_len_nxt = {bus.byte_data, r_len[7:0]};
                    if (w_len_nxt == '0)
                        w_state_nxt = DONE;
                    else if ({1'b0, w_len_nxt} > c_depth)
                        w_state_nxt = ERR;
                    else
                        w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_final_word)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = DONE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = LEN0;
        endcase
    end

    // core_rst follows the registered state, giving one extra reset cycle after DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LEN0;
            r_len        <= '0;
            r_words      <= '0;
            r_addr       <= '0;
            r_byte_ready <= 1'b0;
            r_core_rst   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_byte_ready <= (w_state_nxt == LEN0) || (w_state_nxt == LEN1) ||
                            (w_state_nxt == DATA);
            r_core_rst   <= (r_state != DONE);
            r_load_done  <= (w_state_nxt == DONE);
            r_load_err   <= (w_state_nxt == ERR);
            if (w_word_write) begin
                r_addr  <= r_words[ADDR_W-1:0];
                r_words <= r_words + 1'b1;
            end
        end
    end

    assign bus.byte_ready   = r_byte_ready;
    assign bus.imem_we      = w_pk_valid;
    assign bus.imem_addr    = r_addr;
    assign bus.imem_wdata   = w_pk_word;
    assign bus.core_rst     = r_core_rst;
    assign bus.load_done    = r_load_done;
    assign bus.load_err     = r_load_err;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_loader
// Directed bench for imem_loader with depth-256 and depth-4 instances.
// Rev    : 1.0
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wr_a    = 0;
    int   wr_b    = 0;
    int   wr_mark;
    logic [31:0] mem_a [256];
    logic [31:0] exp_b [4];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus_a ();
    imem_loader_if #(.ADDR_W(2), .DATA_W(32)) bus_b ();

    imem_loader #(.ADDR_W(8), .DATA_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    imem_loader #(.ADDR_W(2), .DATA_W(32)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always @(negedge clk) begin
        if (bus_a.imem_we === 1'b1) begin
            wr_a++;
            mem_a[bus_a.imem_addr] = bus_a.imem_wdata;
        end
        if (bus_b.imem_we === 1'b1) wr_b++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_a(input logic v, input logic [7:0] d);
        bus_a.byte_valid = v;
        bus_a.byte_data  = d;
        tick();
    endtask

    task automatic put_b(input logic v, input logic [7:0] d);
        bus_b.byte_valid = v;
        bus_b.byte_data  = d;
        tick();
    endtask

    task automatic do_reset();
        bus_a.byte_valid = 1'b0;
        bus_b.byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] s1 [10];
        logic       tv [7];
        logic [7:0] tb4 [7];
        logic [7:0] s5 [6];

        bus_a.byte_valid = 1'b0;
        bus_a.byte_data  = 8'h00;
        bus_b.byte_valid = 1'b0;
        bus_b.byte_data  = 8'h00;

        // ---------------- reset values ----------------
        tick();
        chk("rst_ready", bus_a.byte_ready, 0);
        chk("rst_we", bus_a.imem_we, 0);
        chk("rst_addr", bus_a.imem_addr, 0);
        chk("rst_wdata", bus_a.imem_wdata, 0);
        chk("rst_core_rst", bus_a.core_rst, 1);
        chk("rst_done", bus_a.load_done, 0);
        chk("rst_err", bus_a.load_err, 0);
        chk("rst_words", bus_a.words_loaded, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", bus_a.byte_ready, 1);

        // ---------------- two words back-to-back ----------------
        s1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        for (int i = 0; i < 10; i++) begin
            put_a(1'b1, s1[i]);
            if (i == 5) begin
                chk("t1_we0", bus_a.imem_we, 1);
                chk("t1_addr0", bus_a.imem_addr, 0);
                chk("t1_data0", bus_a.imem_wdata, 32'h00000513);
                chk("t1_words1", bus_a.words_loaded, 1);
            end
            if (i >= 6 && i <= 8) chk("t1_gap", bus_a.imem_we, 0);
            if (i == 9) begin
                chk("t1_we1", bus_a.imem_we, 1);
                chk("t1_addr1", bus_a.imem_addr, 1);
                chk("t1_data1", bus_a.imem_wdata, 32'h00100593);
                chk("t1_words2", bus_a.words_loaded, 2);
                chk("t1_done", bus_a.load_done, 1);
                chk("t1_ready_off", bus_a.byte_ready, 0);
                chk("t1_core_rst_held", bus_a.core_rst, 1);
            end
        end
        put_a(1'b0, 8'h00);
        chk("t1_core_rst_rel", bus_a.core_rst, 0);
        chk("t1_we_off", bus_a.imem_we, 0);
        chk("t1_wr_count", wr_a, 2);

        // ---------------- empty program ----------------
        do_reset();
        wr_mark = wr_a;
        put_a(1'b1, 8'h00);
        put_a(1'b1, 8'h00);
        chk("t2_done", bus_a.load_done, 1);
        put_a(1'b0, 8'h00);
        chk("t2_core_rst", bus_a.core_rst, 0);
        chk("t2_words", bus_a.words_loaded, 0);
        chk("t2_no_write", wr_a, wr_mark);

        // ---------------- oversize header N=257 ----------------
        do_reset();
        wr_mark = wr_a;
        put_a(1'b1, 8'h01);
        put_a(1'b1, 8'h01);
        chk("t3_err", bus_a.load_err, 1);
        chk("t3_ready", bus_a.byte_ready, 0);
        for (int i = 0; i < 20; i++) put_a(1'b1, 8'(i));
        put_a(1'b0, 8'h00);
        chk("t3_err_sticky", bus_a.load_err, 1);
        chk("t3_core_rst", bus_a.core_rst, 1);
        chk("t3_done", bus_a.load_done, 0);
        chk("t3_no_write", wr_a, wr_mark);

        // ---------------- stalled source ----------------
        do_reset();
        wr_mark = wr_a;
        put_a(1'b1, 8'h01);
        put_a(1'b1, 8'h00);
        tv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tb4 = '{8'hAA, 8'h55, 8'h55, 8'hBB, 8'h55, 8'hCC, 8'hDD};
        for (int i = 0; i < 7; i++) begin
            put_a(tv[i], tb4[i]);
            if (i < 6) chk("t4_no_early_we", bus_a.imem_we, 0);
        end
        chk("t4_we", bus_a.imem_we, 1);
        chk("t4_data", bus_a.imem_wdata, 32'hDDCCBBAA);
        chk("t4_addr", bus_a.imem_addr, 0);
        put_a(1'b0, 8'h00);
        put_a(1'b0, 8'h00);
        chk("t4_one_write", wr_a, wr_mark + 1);
        chk("t4_done", bus_a.load_done, 1);

        // ---------------- reset mid-load ----------------
        do_reset();
        put_a(1'b1, 8'h02);
        put_a(1'b1, 8'h00);
        for (int i = 0; i < 6; i++) put_a(1'b1, 8'(8'h11 * (i + 1)));
        chk("t5_words_pre", bus_a.words_loaded, 1);
        bus_a.byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rst_words", bus_a.words_loaded, 0);
        chk("t5_rst_core", bus_a.core_rst, 1);
        chk("t5_rst_ready", bus_a.byte_ready, 0);
        chk("t5_rst_wdata", bus_a.imem_wdata, 0);
        rst = 1'b0;
        tick();
        s5 = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 6; i++) put_a(1'b1, s5[i]);
        chk("t5_we", bus_a.imem_we, 1);
        chk("t5_data", bus_a.imem_wdata, 32'hDEADBEEF);
        chk("t5_words", bus_a.words_loaded, 1);
        chk("t5_done", bus_a.load_done, 1);
        put_a(1'b0, 8'h00);
        chk("t5_mem0", mem_a[0], 32'hDEADBEEF);

        // ---------------- depth-4 instance, full fill ----------------
        exp_b = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
        chk("t6_ready", bus_b.byte_ready, 1);
        put_b(1'b1, 8'h04);
        put_b(1'b1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) put_b(1'b1, 8'(16 * k + j));
            chk("t6_we", bus_b.imem_we, 1);
            chk("t6_addr", bus_b.imem_addr, 32'(k));
            chk("t6_data", bus_b.imem_wdata, exp_b[k]);
        end
        chk("t6_words", bus_b.words_loaded, 4);
        chk("t6_done", bus_b.load_done, 1);
        chk("t6_ready_off", bus_b.byte_ready, 0);
        for (int j = 0; j < 4; j++) put_b(1'b1, 8'hF0 + 8'(j));
        put_b(1'b0, 8'h00);
        chk("t6_wr_count", wr_b, 4);
        chk("t6_words_hold", bus_b.words_loaded, 4);
        chk("t6_core_rst", bus_b.core_rst, 0);

        // ---------------- depth-4 instance, N=5 rejected ----------------
        do_reset();
        put_b(1'b1, 8'h05);
        put_b(1'b1, 8'h00);
        chk("t7_err", bus_b.load_err, 1);
        chk("t7_done", bus_b.load_done, 0);
        put_b(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of data_path.
- Accepts a length-prefixed byte stream, packs little-endian bytes into 32-bit words and writes them sequentially into the instruction memory.
- Holds the core in reset until the load completes, then releases it so data_path fetches from PC 0.

Parameters:
ADDR_W, 8, instruction memory word-address width (depth = 2**ADDR_W words)
DATA_W, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
byte_valid  input  1  source has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle (handshake = byte_valid & byte_ready)
imem_we  output  1  one-cycle instruction memory write strobe
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
core_rst  output  1  reset to data_path; high until load done
load_done  output  1  load completed successfully (sticky)
load_err  output  1  header length exceeds depth (sticky)
words_loaded  output  ADDR_W+1  count of words written so far

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, load_err=0, words_loaded=0, state=LEN0, byte counter=0, length=0.
- Stream format: byte0 = len[7:0], byte1 = len[15:8] (N = number of words), then 4*N bytes, least significant byte of each word first.
- byte_ready is a registered output: 1 in LEN0, LEN1 and DATA, otherwise 0. It is 1 from the first cycle after rst deasserts.
- States:
  - LEN0: on handshake, latch len[7:0] -> LEN1.
  - LEN1: on handshake, latch len[15:8], then evaluate:
    - N==0 -> DONE.
    - N > 2**ADDR_W -> ERR.
    - Otherwise -> DATA.
  - DATA: each handshake shifts the byte into the word assembly register at lane byte_cnt (0..3), then byte_cnt++.
    - On the handshake with byte_cnt==3: next cycle imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = words_loaded (pre-increment); words_loaded increments in the same cycle.
    - When the written word is the Nth: move to DONE in the same cycle as the strobe.
  - DONE: byte_ready=0, load_done=1. core_rst deasserts the cycle after entering DONE, so data_path sees one extra reset cycle after the final write lands.
  - ERR: byte_ready=0, load_err=1, core_rst stays 1. Terminal until rst.
- Write latency: imem_we asserts exactly 1 cycle after the 4th byte handshake of a word.
- Back-to-back bytes (byte_valid held high) are accepted every cycle with no bubbles; word strobes occur every 4 cycles.
- Source stalls (byte_valid=0) in any state hold all state; partial word contents are preserved.
- N == 2**ADDR_W is legal: the final address is 2**ADDR_W-1, and words_loaded reaches 2**ADDR_W, which is why it is ADDR_W+1 bits wide.
- Bytes presented in DONE/ERR are not accepted (byte_ready=0) and have no effect.
- rst mid-load: everything returns to reset values in the next cycle and core_rst reasserts. The next load restarts at LEN0 and overwrites from address 0; words already written are not cleared.
- rst takes priority over every other event in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding localparams: LEN0=3'd0, LEN1=3'd1, DATA=3'd2, DONE=3'd3, ERR=3'd4
  - BYTES_PER_WORD=4
  - HDR_BYTES=2
- One natural sub-module, byte_packer:
  - inputs: byte, strobe, clear
  - outputs: 32-bit word, word_valid pulse
  - responsibility: lane counter and little-endian assembly
- The top holds the FSM, address counter and core_rst logic.

Test Plan:
- Header 0x02,0x00 then bytes 13,05,00,00, 93,05,10,00 streamed back-to-back -> imem_we pulses at addr 0 data 0x00000513 and addr 1 data 0x00100593, 4 cycles apart. load_done=1, core_rst falls 1 cycle after DONE entry, words_loaded=2.
- Header 0x00,0x00 -> no imem_we, load_done=1, core_rst=0 within 2 cycles of the second header byte.
- ADDR_W=8, header 0x01,0x01 (N=257) -> load_err=1, byte_ready=0, core_rst stays 1, no imem_we for 20 following bytes.
- One word streamed with byte_valid toggling 1,0,0,1,0,1,1 -> word 0xDDCCBBAA written once (bytes AA,BB,CC,DD), strobe 1 cycle after the DD handshake, no extra strobes.
- rst asserted after 6 of 8 data bytes, then a full 1-word stream 0x01,0x00,EF,BE,AD,DE -> addr 0 = 0xDEADBEEF, words_loaded=1, load_done=1.
- ADDR_W=2, N=4 -> writes addr 0..3, words_loaded=4, load_done=1. A 5th data word streamed afterwards is ignored (byte_ready=0).
